spi_ram_burst: RTL and testbench

//  Parametrised single-port RAM behind the SPI slave command stream; successor to the fixed 256x8 RAM.

---
 rtl/spi_ram_pkg.sv | 20 ++
 rtl/spi_ram_array.sv | 38 +++
 rtl/spi_ram_burst.sv | 157 +++++++++++++++
 tb/tb_spi_ram_burst.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// Shared types and limits for the burst-capable SPI RAM.
package spi_ram_pkg;

    localparam int unsigned MAX_RD_LATENCY = 4;
    localparam int unsigned CNT_W          = 2;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RD_PEND = 2'b01,
        RD_OUT  = 2'b10
    } state_e;

endpackage

// File: rtl/spi_ram_array.sv
// Single-port storage array: synchronous write, registered read port.
module spi_ram_array #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read register holds its value between reads; it alone is reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/spi_ram_burst.sv
// Command decoder, read sequencer and address registers in front of the RAM array.
module spi_ram_burst
    import spi_ram_pkg::*;
#(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned AUTO_INC   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [DATA_W+1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    output logic              busy,
    output logic              err
);

    if (ADDR_W > DATA_W) begin : g_chk_addr_w
        $error("spi_ram_burst: ADDR_W must not exceed DATA_W");
    end
    if ((RD_LATENCY < 1) || (RD_LATENCY > MAX_RD_LATENCY)) begin : g_chk_latency
        $error("spi_ram_burst: RD_LATENCY out of range 1..MAX_RD_LATENCY");
    end

    state_e             state_q,    state_d;
    logic [ADDR_W-1:0]  wr_addr_q,  wr_addr_d;
    logic [ADDR_W-1:0]  rd_addr_q,  rd_addr_d;
    logic               rd_armed_q, rd_armed_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic               busy_q,     busy_d;
    logic               err_q,      err_d;
    logic               tx_valid_q, tx_valid_d;

    logic               we_c;
    logic               re_c;
    logic [ADDR_W-1:0]  mem_addr_c;
    cmd_e               cmd_c;
    logic [DATA_W-1:0]  payload_c;

    assign cmd_c     = cmd_e'(din[DATA_W+1:DATA_W]);
    assign payload_c = din[DATA_W-1:0];

    // Next-state logic: command decode in IDLE, latency countdown, drop-and-flag when not idle.
    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        rd_armed_d = rd_armed_q;
        cnt_d      = cnt_q;
        busy_d     = 1'b0;
        err_d      = 1'b0;
        tx_valid_d = 1'b0;
        we_c       = 1'b0;
        re_c       = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    case (cmd_c)
                        CMD_WR_ADDR: begin
                            wr_addr_d = payload_c[ADDR_W-1:0];
                        end
                        CMD_WR_DATA: begin
                            we_c = 1'b1;
                            if (AUTO_INC != 0) begin
                                wr_addr_d = wr_addr_q + ADDR_W'(1);
                            end
                        end
                        CMD_RD_ADDR: begin
                            rd_addr_d  = payload_c[ADDR_W-1:0];
                            rd_armed_d = 1'b1;
                        end
                        CMD_RD_DATA: begin
                            if (rd_armed_q) begin
                                state_d = RD_PEND;
                                cnt_d   = CNT_W'(RD_LATENCY - 1);
                                busy_d  = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            RD_PEND: begin
                err_d = rx_valid;
                if (cnt_q == '0) begin
                    re_c       = 1'b1;
                    tx_valid_d = 1'b1;
                    state_d    = RD_OUT;
                    if (AUTO_INC != 0) begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                    end else begin
                        rd_armed_d = 1'b0;
                    end
                end else begin
                    cnt_d  = cnt_q - CNT_W'(1);
                    busy_d = 1'b1;
                end
            end
            RD_OUT: begin
                err_d   = rx_valid;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reads and writes never overlap, so one address port serves both.
    assign mem_addr_c = re_c ? rd_addr_q : wr_addr_q;

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            rd_armed_q <= 1'b0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            rd_armed_q <= rd_armed_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    spi_ram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (we_c),
        .re_i    (re_c),
        .addr_i  (mem_addr_c),
        .wdata_i (payload_c),
        .rdata_o (dout)
    );

    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_spi_ram_burst.sv
// Self-checking bench: four configurations share one command stream, each tracked by a transaction-level model.
module tb_spi_ram_burst;

    localparam int NI = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_valid;
    logic [9:0] din;

    logic [7:0] dout_w [NI];
    logic       tx_w   [NI];
    logic       busy_w [NI];
    logic       err_w  [NI];

    always #5 clk = ~clk;

    spi_ram_burst #(.ADDR_W(8), .DATA_W(8), .RD_LATENCY(1), .AUTO_INC(1)) u0 (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .din(din),
        .dout(dout_w[0]), .tx_valid(tx_w[0]), .busy(busy_w[0]), .err(err_w[0]));
    spi_ram_burst #(.ADDR_W(8), .DATA_W(8), .RD_LATENCY(3), .AUTO_INC(1)) u1 (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .din(din),
        .dout(dout_w[1]), .tx_valid(tx_w[1]), .busy(busy_w[1]), .err(err_w[1]));
    spi_ram_burst #(.ADDR_W(8), .DATA_W(8), .RD_LATENCY(2), .AUTO_INC(1)) u2 (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .din(din),
        .dout(dout_w[2]), .tx_valid(tx_w[2]), .busy(busy_w[2]), .err(err_w[2]));
    spi_ram_burst #(.ADDR_W(8), .DATA_W(8), .RD_LATENCY(1), .AUTO_INC(0)) u3 (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .din(din),
        .dout(dout_w[3]), .tx_valid(tx_w[3]), .busy(busy_w[3]), .err(err_w[3]));

    function automatic int lat_of(int i);
        case (i)
            1:       return 3;
            2:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic bit inc_of(int i);
        return (i != 3);
    endfunction

    // Reference model: per-instance memory, pointers, and the edge numbers of the pending read.
    logic [7:0] m_mem  [NI][256];
    bit         m_kn   [NI][256];
    logic [7:0] m_wa   [NI];
    logic [7:0] m_ra   [NI];
    bit         m_arm  [NI];
    bit         m_pend [NI];
    int         m_fire [NI];
    int         m_acc  [NI];

    bit         e_tx   [NI];
    bit         e_err  [NI];
    bit         e_busy [NI];
    logic [7:0] e_dout [NI];
    bit         e_dkn  [NI];

    int n = 0;
    int checks = 0;
    int errors = 0;

    function automatic void model_reset();
        for (int i = 0; i < NI; i++) begin
            m_wa[i] = 8'h00; m_ra[i] = 8'h00; m_arm[i] = 1'b0;
            m_pend[i] = 1'b0; m_fire[i] = 0; m_acc[i] = 0;
            e_tx[i] = 1'b0; e_err[i] = 1'b0; e_busy[i] = 1'b0;
            e_dout[i] = 8'h00; e_dkn[i] = 1'b1;
        end
    endfunction

    function automatic void model_step(bit v, logic [9:0] d);
        for (int i = 0; i < NI; i++) begin
            e_tx[i]  = 1'b0;
            e_err[i] = 1'b0;
            if (m_pend[i] && (n == m_fire[i])) begin
                e_tx[i]   = 1'b1;
                e_dout[i] = m_mem[i][m_ra[i]];
                e_dkn[i]  = m_kn[i][m_ra[i]];
                m_pend[i] = 1'b0;
                if (inc_of(i)) m_ra[i] = m_ra[i] + 8'd1;
                else           m_arm[i] = 1'b0;
            end
            if (v) begin
                if (n < m_acc[i]) begin
                    e_err[i] = 1'b1;
                end else begin
                    case (d[9:8])
                        2'b00: m_wa[i] = d[7:0];
                        2'b01: begin
                            m_mem[i][m_wa[i]] = d[7:0];
                            m_kn[i][m_wa[i]]  = 1'b1;
                            if (inc_of(i)) m_wa[i] = m_wa[i] + 8'd1;
                        end
                        2'b10: begin
                            m_ra[i]  = d[7:0];
                            m_arm[i] = 1'b1;
                        end
                        default: begin
                            if (m_arm[i]) begin
                                m_pend[i] = 1'b1;
                                m_fire[i] = n + lat_of(i);
                                m_acc[i]  = n + lat_of(i) + 2;
                            end else begin
                                e_err[i] = 1'b1;
                            end
                        end
                    endcase
                end
            end
            e_busy[i] = m_pend[i];
        end
    endfunction

    task automatic chk(string nm, int i, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s inst%0d edge%0d got %0h want %0h", nm, i, n, act, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            chk("tx_valid", i, 32'(tx_w[i]), 32'(e_tx[i]));
            chk("err", i, 32'(err_w[i]), 32'(e_err[i]));
            chk("busy", i, 32'(busy_w[i]), 32'(e_busy[i]));
            if (e_dkn[i]) chk("dout", i, 32'(dout_w[i]), 32'(e_dout[i]));
        end
    endtask

    // Called at a falling edge: drive, let one rising edge pass, then compare.
    task automatic tick(input bit v, input logic [9:0] d);
        rx_valid = v;
        din      = d;
        @(posedge clk);
        model_step(v, d);
        n++;
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int cnt);
        for (int c = 0; c < cnt; c++) tick(1'b0, 10'h000);
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit         v;
        logic [9:0] d;
        bit         tx;
        logic [7:0] dout;
        bit         err;
        bit         busy;
    } vec_t;

    vec_t tab [14];

    logic [7:0] saved;
    logic [1:0] rc;
    logic [7:0] rp;

    initial begin
        // Burst write across the wrap point, then three reads (instance 0: latency 1, auto-increment).
        tab[0]  = '{1'b1, 10'h0FE, 1'b0, 8'h00, 1'b0, 1'b0};
        tab[1]  = '{1'b1, 10'h1A1, 1'b0, 8'h00, 1'b0, 1'b0};
        tab[2]  = '{1'b1, 10'h1A2, 1'b0, 8'h00, 1'b0, 1'b0};
        tab[3]  = '{1'b1, 10'h1A3, 1'b0, 8'h00, 1'b0, 1'b0};
        tab[4]  = '{1'b1, 10'h2FE, 1'b0, 8'h00, 1'b0, 1'b0};
        tab[5]  = '{1'b1, 10'h300, 1'b0, 8'h00, 1'b0, 1'b1};
        tab[6]  = '{1'b0, 10'h000, 1'b1, 8'hA1, 1'b0, 1'b0};
        tab[7]  = '{1'b0, 10'h000, 1'b0, 8'hA1, 1'b0, 1'b0};
        tab[8]  = '{1'b1, 10'h300, 1'b0, 8'hA1, 1'b0, 1'b1};
        tab[9]  = '{1'b0, 10'h000, 1'b1, 8'hA2, 1'b0, 1'b0};
        tab[10] = '{1'b0, 10'h000, 1'b0, 8'hA2, 1'b0, 1'b0};
        tab[11] = '{1'b1, 10'h300, 1'b0, 8'hA2, 1'b0, 1'b1};
        tab[12] = '{1'b0, 10'h000, 1'b1, 8'hA3, 1'b0, 1'b0};
        tab[13] = '{1'b0, 10'h000, 1'b0, 8'hA3, 1'b0, 1'b0};

        for (int i = 0; i < NI; i++)
            for (int a = 0; a < 256; a++) begin
                m_mem[i][a] = 8'h00;
                m_kn[i][a]  = 1'b0;
            end

        rst_n    = 1'b0;
        rx_valid = 1'b0;
        din      = 10'h000;
        model_reset();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Unarmed read straight after reset.
        tick(1'b1, 10'h300);
        chk("unarmed_err", 0, 32'(err_w[0]), 1);
        chk("unarmed_tx", 0, 32'(tx_w[0]), 0);
        tick(1'b0, 10'h000);
        chk("unarmed_err_clr", 0, 32'(err_w[0]), 0);
        idle(2);

        do_reset();
        for (int r = 0; r < 14; r++) begin
            tick(tab[r].v, tab[r].d);
            chk("tab_tx", 0, 32'(tx_w[0]), 32'(tab[r].tx));
            chk("tab_dout", 0, 32'(dout_w[0]), 32'(tab[r].dout));
            chk("tab_err", 0, 32'(err_w[0]), 32'(tab[r].err));
            chk("tab_busy", 0, 32'(busy_w[0]), 32'(tab[r].busy));
        end
        idle(6);

        // Fill every address with random data so all later reads are predictable.
        do_reset();
        for (int a = 0; a < 256; a++) begin
            tick(1'b1, {2'b00, 8'(a)});
            tick(1'b1, {2'b01, 8'($urandom)});
        end
        idle(6);

        // Latency 3 (instance 1): busy for three samples, a single tx_valid on the fourth.
        do_reset();
        tick(1'b1, 10'h210);
        tick(1'b1, 10'h300);
        chk("lat_busy0", 1, 32'(busy_w[1]), 1);
        tick(1'b0, 10'h000);
        chk("lat_busy1", 1, 32'(busy_w[1]), 1);
        chk("lat_tx1", 1, 32'(tx_w[1]), 0);
        tick(1'b0, 10'h000);
        chk("lat_busy2", 1, 32'(busy_w[1]), 1);
        chk("lat_tx2", 1, 32'(tx_w[1]), 0);
        tick(1'b0, 10'h000);
        chk("lat_tx3", 1, 32'(tx_w[1]), 1);
        chk("lat_busy3", 1, 32'(busy_w[1]), 0);
        chk("lat_dout", 1, 32'(dout_w[1]), 32'(m_mem[1][8'h10]));
        tick(1'b0, 10'h000);
        chk("lat_tx4", 1, 32'(tx_w[1]), 0);
        idle(4);

        // Overrun (instance 2, latency 2): write dropped during the pending read.
        do_reset();
        saved = m_mem[2][0];
        tick(1'b1, 10'h230);
        tick(1'b1, 10'h300);
        tick(1'b1, 10'h155);
        chk("ovr_err", 2, 32'(err_w[2]), 1);
        tick(1'b0, 10'h000);
        chk("ovr_tx", 2, 32'(tx_w[2]), 1);
        chk("ovr_dout", 2, 32'(dout_w[2]), 32'(m_mem[2][8'h30]));
        chk("ovr_err_clr", 2, 32'(err_w[2]), 0);
        idle(6);
        tick(1'b1, 10'h200);
        tick(1'b1, 10'h300);
        idle(6);
        chk("ovr_mem_kept", 2, 32'(dout_w[2]), 32'(saved));

        // No auto-increment (instance 3): a second read without a new address is an error.
        do_reset();
        tick(1'b1, 10'h220);
        tick(1'b1, 10'h300);
        tick(1'b0, 10'h000);
        chk("noinc_tx", 3, 32'(tx_w[3]), 1);
        chk("noinc_dout", 3, 32'(dout_w[3]), 32'(m_mem[3][8'h20]));
        idle(5);
        tick(1'b1, 10'h300);
        chk("noinc_err", 3, 32'(err_w[3]), 1);
        for (int c = 0; c < 5; c++) begin
            tick(1'b0, 10'h000);
            chk("noinc_no_tx", 3, 32'(tx_w[3]), 0);
        end

        // Reset in the middle of a pending read (instance 1).
        do_reset();
        tick(1'b1, 10'h240);
        tick(1'b1, 10'h300);
        tick(1'b0, 10'h000);
        chk("rst_pend_busy", 1, 32'(busy_w[1]), 1);
        do_reset();
        chk("rst_dout", 1, 32'(dout_w[1]), 0);
        for (int c = 0; c < 6; c++) begin
            tick(1'b0, 10'h000);
            chk("rst_no_tx", 1, 32'(tx_w[1]), 0);
        end

        // Random command stream.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rc = 2'($urandom_range(0, 3));
            rp = 8'($urandom);
            tick($urandom_range(0, 3) != 0, {rc, rp});
        end
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
